// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// One product bit per BUSY cycle, fixed N-cycle latency, valid/ready handshakes.
module seq_multiplier #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] operand_a,
    input  logic [N-1:0] operand_b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned W2 = 2 * N;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULH   = 2'd1;
    localparam logic [1:0] OP_MULHSU = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [W2-1:0]   mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic            neg_q, neg_d;
    logic [1:0]      op_q, op_d;
    logic [N-1:0]    result_q, result_d;
    logic            out_valid_q, out_valid_d;

    logic            a_neg, b_neg;
    logic [N-1:0]    a_mag, b_mag;
    logic [W2-1:0]   step_sum;
    logic [W2-1:0]   prod;

    // Held low during reset so a request is never offered while the block is being cleared.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        neg_d       = neg_q;
        op_d        = op_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        a_neg       = 1'b0;
        b_neg       = 1'b0;
        a_mag       = '0;
        b_mag       = '0;
        step_sum    = '0;
        prod        = '0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    // The most-negative value negates to itself, which read unsigned is 2^(N-1).
                    a_neg    = ((op == OP_MULH) || (op == OP_MULHSU)) && operand_a[N-1];
                    b_neg    = (op == OP_MULH) && operand_b[N-1];
                    a_mag    = a_neg ? (~operand_a + N'(1)) : operand_a;
                    b_mag    = b_neg ? (~operand_b + N'(1)) : operand_b;
                    mcand_d  = {{N{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = a_neg ^ b_neg;
                    op_d     = op;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                step_sum = acc_q + (mplier_q[0] ? mcand_q : {W2{1'b0}});
                acc_d    = step_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    prod        = neg_q ? (~step_sum + W2'(1)) : step_sum;
                    result_d    = (op_q == OP_MUL) ? prod[N-1:0] : prod[W2-1:N];
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            neg_q       <= 1'b0;
            op_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            neg_q       <= neg_d;
            op_q        <= op_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed corner vectors, stall/reset cases,
// then 1000 random requests checked against a 64-bit reference product.
module tb_seq_multiplier;

    localparam int unsigned N = 32;
    localparam int unsigned LAT = N + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  operand_a;
    logic [N-1:0]  operand_b;
    logic [1:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  result;

    seq_multiplier #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic hold_ready = 1'b0;
    logic rand_stall = 1'b0;

    logic [N-1:0] exp_q[$];
    string        name_q[$];
    int           acc_cq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
    endtask

    task automatic chk_fail(input string nm);
        n_checks++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [1:0] o);
        logic [63:0] ae, be, p;
        ae = (o == 2'd1 || o == 2'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        be = (o == 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ae * be;
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // out_ready driver: offset from the edge so main-flow updates of hold_ready land first
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (hold_ready) out_ready = 1'b0;
            else if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
        end
    end

    // Monitor: acceptance times, latency on out_valid rise, result on output handshake
    initial begin
        logic prev_ov;
        int   t0;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_cq.delete();
                prev_ov = 1'b0;
            end else begin
                if (in_valid && in_ready) acc_cq.push_back(cyc);
                if (out_valid && !prev_ov) begin
                    if (acc_cq.size() == 0) chk_fail("latency: out_valid with no accepted request");
                    else begin
                        t0 = acc_cq.pop_front();
                        chk("latency", N'(cyc - t0), N'(LAT));
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk_fail("unexpected result handshake");
                    else chk(name_q.pop_front(), result, exp_q.pop_front());
                end
                prev_ov = out_valid;
            end
        end
    end

    // Issue one request; returns at posedge+1 after the acceptance edge
    task automatic issue(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [1:0] o, input logic [N-1:0] expv);
        logic acc;
        int   k;
        exp_q.push_back(expv);
        name_q.push_back(nm);
        in_valid  = 1'b1;
        operand_a = a;
        operand_b = b;
        op        = o;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        in_valid  = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        op        = 2'($urandom_range(0, 3));
        if (!acc) begin
            chk_fail({nm, ": in_ready timeout"});
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            chk_fail("drain timeout");
            exp_q.delete();
            name_q.delete();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] a, b;
        logic [1:0]   o;
        logic         saw_ov;
        int           k;

        rst       = 1'b1;
        in_valid  = 1'b0;
        operand_a = '0;
        operand_b = '0;
        op        = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("in_ready during reset", N'(in_ready), N'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", N'(out_valid), N'(0));
        chk("reset result", result, N'(0));
        chk("in_ready after reset", N'(in_ready), N'(1));
        @(posedge clk);
        #1;

        // Directed corner vectors
        issue("MUL -7*3", 32'hFFFF_FFF9, 32'd3, 2'd0, 32'hFFFF_FFEB);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("result held after DONE->IDLE", result, 32'hFFFF_FFEB);
        @(posedge clk);
        #1;
        issue("MULH -7*3", 32'hFFFF_FFF9, 32'd3, 2'd1, 32'hFFFF_FFFF);
        issue("MULH minneg*minneg", 32'h8000_0000, 32'h8000_0000, 2'd1, 32'h4000_0000);
        issue("MULHU max*max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 32'hFFFF_FFFE);
        issue("MULHSU -1*2", 32'hFFFF_FFFF, 32'd2, 2'd2, 32'hFFFF_FFFF);
        issue("MULHSU minneg*umax", 32'h8000_0000, 32'hFFFF_FFFF, 2'd2, 32'h8000_0000);
        issue("MULHU 2^31*2", 32'h8000_0000, 32'd2, 2'd3, 32'h0000_0001);
        issue("MUL zero*x", 32'd0, 32'h1234_5678, 2'd0, 32'd0);
        issue("MULH minneg*-1", 32'h8000_0000, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000);
        wait_idle();

        // in_valid pulsed while BUSY must be ignored
        issue("MUL 9*11 with busy pulse", 32'd9, 32'd11, 2'd0, 32'd99);
        repeat (4) @(posedge clk);
        #1;
        in_valid  = 1'b1;
        operand_a = 32'd1000;
        operand_b = 32'd1000;
        op        = 2'd0;
        @(negedge clk);
        chk("in_ready low in BUSY", N'(in_ready), N'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();

        // Output stalled for 10 cycles in DONE
        hold_ready = 1'b1;
        issue("MUL 5*5 stalled", 32'd5, 32'd5, 2'd0, 32'd25);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) chk_fail("stall: out_valid timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall out_valid", N'(out_valid), N'(1));
            chk("stall result", result, N'(25));
            chk("stall in_ready", N'(in_ready), N'(0));
        end
        @(posedge clk);
        #1;
        hold_ready = 1'b0;
        wait_idle();

        // Reset at BUSY step 15 abandons the request
        issue("abandoned", 32'd123, 32'd456, 2'd0, 32'd56088);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready low while rst", N'(in_ready), N'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        void'(name_q.pop_back());
        @(negedge clk);
        chk("in_ready after mid-op reset", N'(in_ready), N'(1));
        saw_ov = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) saw_ov = 1'b1;
        end
        chk("no out_valid after abandon", N'(saw_ov), N'(0));
        @(posedge clk);
        #1;
        issue("MUL 6*7 after reset", 32'd6, 32'd7, 2'd0, 32'h0000_002A);
        wait_idle();

        // Random requests with random output stalls
        rand_stall = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: a = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'd0;
                default: ;
            endcase
            issue($sformatf("rand %0d op%0d %08h*%08h", i, o, a, b), a, b, o, ref_mul(a, b, o));
        end
        wait_idle();
        rand_stall = 1'b0;
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter N, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port operand_a  input  N  multiplicand, driven by the upstream operand-select mux.
REQ-007 SHALL have port operand_b  input  N  multiplier, driven by the upstream operand-select mux.
REQ-008 SHALL have port op  input  2  0=MUL (low N bits), 1=MULH (signed x signed, high N), 2=MULHSU (signed a x unsigned b, high N), 3=MULHU (unsigned x unsigned, high N).
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port result  output  N  selected half of the 2N-bit product.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL assert in_ready only in IDLE; in_valid in any other state is ignored.
REQ-014 SHALL accept on the edge with in_valid=1 and in_ready=1: latch operand_a, operand_b, op; go IDLE->BUSY with step counter 0.
REQ-015 SHALL ignore operand_a/operand_b/op changes after acceptance until the next acceptance.
REQ-016 SHALL, at acceptance, convert signed operands (per op) to magnitudes and record product sign = XOR of operand signs that are treated as signed.
REQ-017 SHALL perform one shift-add step per BUSY cycle on the unsigned magnitudes, with a 2N-bit accumulator.
REQ-018 SHALL leave BUSY after exactly N steps; the final edge applies the two's-complement negation of the 2N-bit accumulator when the sign is 1, loads result, and enters DONE.
REQ-019 SHALL give fixed latency: acceptance edge in cycle t gives out_valid=1 from cycle t+N+1 (cycle t+33 for N=32), independent of operand values.
REQ-020 SHALL, for op=0, output product bits [N-1:0]; for op=1..3, bits [2N-1:N].
REQ-021 SHALL assert out_valid only in DONE; DONE->IDLE on the edge with out_ready=1.
REQ-022 SHALL hold result and out_valid stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-023 SHALL keep result at its last value after the DONE->IDLE transition until the next DONE load.
REQ-024 SHALL not overlap output and input handshakes: minimum issue interval is N+2 cycles.
REQ-025 SHALL handle a most-negative operand (0x80000000 for N=32) with a correct magnitude of 2^(N-1) (N+1-bit-safe magnitude path, no overflow).
REQ-026 SHALL treat a zero operand like any other value: no early termination, same latency.

Reset
REQ-027 SHALL, while rst=1 on an edge, force state IDLE, step counter 0, accumulator 0, result 0, out_valid 0.
REQ-028 SHALL drive in_ready=0 while rst=1, and in_ready=1 in the first cycle after rst deasserts.
REQ-029 SHALL let rst in BUSY or DONE abandon the operation; no out_valid is produced for that request.

Verification
REQ-030 Bench SHALL cover: MUL a=0xFFFFFFF9 (-7), b=3 -> result 0xFFFFFFEB, out_valid exactly 33 cycles after acceptance.
REQ-031 Bench SHALL cover: MULH -7 x 3 -> 0xFFFFFFFF; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-032 Bench SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-033 Bench SHALL cover: out_ready held 0 for 10 cycles in DONE -> result/out_valid unchanged, in_ready=0 throughout; in_valid pulsed during BUSY -> ignored.
REQ-034 Bench SHALL cover: rst=1 for one cycle at BUSY step 15 -> out_valid stays 0, in_ready=1 next cycle; a new MUL 6x7 then returns 0x0000002A.
REQ-035 Bench SHALL cover: 1000 random operand/op requests with random out_ready stalls -> every result equals a 64-bit reference-model product, with an assertion per transaction.
